// File: rtl/syscall_display_ctrl.sv
// Syscall display front-end: buffers captured display words in a FIFO and
// streams each one as ASCII hex digits (MSB first) plus a separator over valid/ready.
module syscall_display_ctrl #(
    parameter int         DATA_W   = 16,
    parameter int         DEPTH    = 8,
    parameter logic [7:0] SEP_CHAR = 8'h0A,
    parameter bit         UPPER    = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        data,
    input  logic                     call,
    output logic [7:0]               char_out,
    output logic                     char_valid,
    input  logic                     char_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     overflow
);
    localparam int NIB   = DATA_W / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, EMIT, SEP} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   nib_idx_reg, nib_idx_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               overflow_reg, overflow_next;
    logic               call_q_reg;
    logic               busy_reg;
    logic [DATA_W-1:0]  word_reg;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [3:0]         nibbles [NIB];

    logic push_req, push_ok, pop;

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return (UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign nibbles[gi] = word_reg[4*gi +: 4];
        end
    endgenerate

    assign push_req = call & ~call_q_reg;
    assign pop      = (state_reg == IDLE) && (count_reg != '0);
    // A full FIFO still takes a word if the head leaves on the same edge.
    assign push_ok  = push_req && ((count_reg < CNT_W'(DEPTH)) || pop);

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (push_ok)
            wr_ptr_next = wr_ptr_reg + 1'b1;
        if (pop)
            rd_ptr_next = rd_ptr_reg + 1'b1;
        if (push_req && !push_ok)
            overflow_next = 1'b1;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        nib_idx_next = nib_idx_reg;
        char_valid   = 1'b0;
        char_out     = 8'h00;
        case (state_reg)
            IDLE: begin
                if (pop) begin
                    nib_idx_next = IDX_W'(NIB - 1);
                    state_next   = EMIT;
                end
            end
            EMIT: begin
                char_valid = 1'b1;
                char_out   = to_ascii(nibbles[nib_idx_reg]);
                if (char_ready) begin
                    if (nib_idx_reg == '0)
                        state_next = SEP;
                    else
                        nib_idx_next = nib_idx_reg - 1'b1;
                end
            end
            SEP: begin
                char_valid = 1'b1;
                char_out   = SEP_CHAR;
                if (char_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            nib_idx_reg  <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            call_q_reg   <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            nib_idx_reg  <= nib_idx_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            call_q_reg   <= call;
            busy_reg     <= (state_next != IDLE) || (count_next != '0);
        end
    end

    // Storage has no reset so it maps onto block RAM; the pop is its registered read.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= data;
        if (pop)
            word_reg <= mem[rd_ptr_reg];
    end

    assign fifo_count = count_reg;
    assign busy       = busy_reg;
    assign overflow   = overflow_reg;

endmodule
